// File: rtl/pong_ctrl.sv
// Pong game sequencer: ball motion, paddle move pulses, collision-check windows, scoring.
// Optional PONG_SPEEDUP_EN halves the tick period once a rally reaches 8 consecutive hits.
module pong_ctrl #(
    parameter int TICK_DIV  = 1000000,
    parameter int WIN_SCORE = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btnUpL,
    input  logic       btnDownL,
    input  logic       btnUpR,
    input  logic       btnDownR,
    input  logic       hitL,
    input  logic       hitR,
    output logic       moveUpL,
    output logic       moveDownL,
    output logic       moveUpR,
    output logic       moveDownR,
    output logic       inRangeL,
    output logic       inRangeR,
    output logic [5:0] ballX,
    output logic [4:0] ballY,
    output logic [3:0] scoreL,
    output logic [3:0] scoreR,
    output logic       gameOver
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] FULL_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    typedef enum logic [2:0] {IDLE, MOVE, CHKL, WAITL, CHKR, WAITR, POINT, OVER} stateT;

    stateT         state, stateNext;
    logic [CW-1:0] tickCnt;
    logic [CW-1:0] tickLast;
    logic          tick;
    logic [3:0]    sync1, sync2;
    logic          dxPos, dyPos;
    logic          dxNext, dyNext;
    logic [5:0]    xNext;
    logic [4:0]    yNext;
    logic [3:0]    scoreLNext, scoreRNext;
    logic          pulseEn;

`ifdef PONG_SPEEDUP_EN
    localparam logic [CW-1:0] HALF_LAST = CW'(TICK_DIV / 2 - 1);
    logic [3:0] rally, rallyNext;
    assign tickLast = (rally >= 4'd8) ? HALF_LAST : FULL_LAST;
`else
    assign tickLast = FULL_LAST;
`endif

    // >= so a switch to the shorter period never lets the counter run past its wrap point
    assign tick = (tickCnt >= tickLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tick ? '0 : tickCnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btnUpL, btnDownL, btnUpR, btnDownR};
            sync2 <= sync1;
        end
    end

    always_comb begin
        stateNext  = state;
        xNext      = ballX;
        yNext      = ballY;
        dxNext     = dxPos;
        dyNext     = dyPos;
        scoreLNext = scoreL;
        scoreRNext = scoreR;
`ifdef PONG_SPEEDUP_EN
        rallyNext  = rally;
`endif
        case (state)
            IDLE: begin
                if (start) stateNext = MOVE;
            end
            MOVE: begin
                if (tick) begin
                    if (dyPos && ballY == 5'd31) begin
                        dyNext = 1'b0;
                        yNext  = 5'd30;
                    end else if (!dyPos && ballY == 5'd0) begin
                        dyNext = 1'b1;
                        yNext  = 5'd1;
                    end else if (dyPos) begin
                        yNext = ballY + 5'd1;
                    end else begin
                        yNext = ballY - 5'd1;
                    end
                    if (dxPos) begin
                        if (ballX == 6'd62) stateNext = CHKR;
                        else                xNext     = ballX + 6'd1;
                    end else begin
                        if (ballX == 6'd1) stateNext = CHKL;
                        else               xNext     = ballX - 6'd1;
                    end
                end
            end
            CHKL: stateNext = WAITL;
            CHKR: stateNext = WAITR;
            WAITL: begin
                if (hitL) begin
                    dxNext    = 1'b1;
                    stateNext = MOVE;
`ifdef PONG_SPEEDUP_EN
                    if (rally != 4'd15) rallyNext = rally + 4'd1;
`endif
                end else begin
                    if (scoreR < WIN) scoreRNext = scoreR + 4'd1;
                    stateNext = POINT;
                end
            end
            WAITR: begin
                if (hitR) begin
                    dxNext    = 1'b0;
                    stateNext = MOVE;
`ifdef PONG_SPEEDUP_EN
                    if (rally != 4'd15) rallyNext = rally + 4'd1;
`endif
                end else begin
                    if (scoreL < WIN) scoreLNext = scoreL + 4'd1;
                    stateNext = POINT;
                end
            end
            POINT: begin
                // dx still points at the side that just missed, which is where the serve goes
                xNext = 6'd32;
                yNext = 5'd16;
`ifdef PONG_SPEEDUP_EN
                rallyNext = 4'd0;
`endif
                if (scoreL == WIN || scoreR == WIN) stateNext = OVER;
                else                                stateNext = IDLE;
            end
            OVER: begin
                if (start) begin
                    scoreLNext = 4'd0;
                    scoreRNext = 4'd0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ballX  <= 6'd32;
            ballY  <= 5'd16;
            dxPos  <= 1'b1;
            dyPos  <= 1'b1;
            scoreL <= 4'd0;
            scoreR <= 4'd0;
`ifdef PONG_SPEEDUP_EN
            rally  <= 4'd0;
`endif
        end else begin
            state  <= stateNext;
            ballX  <= xNext;
            ballY  <= yNext;
            dxPos  <= dxNext;
            dyPos  <= dyNext;
            scoreL <= scoreLNext;
            scoreR <= scoreRNext;
`ifdef PONG_SPEEDUP_EN
            rally  <= rallyNext;
`endif
        end
    end

    assign pulseEn   = tick && (state != POINT) && (state != OVER);
    assign moveUpL   = pulseEn && sync2[3] && !sync2[2];
    assign moveDownL = pulseEn && sync2[2] && !sync2[3];
    assign moveUpR   = pulseEn && sync2[1] && !sync2[0];
    assign moveDownR = pulseEn && sync2[0] && !sync2[1];
    assign inRangeL  = (state == CHKL);
    assign inRangeR  = (state == CHKR);
    assign gameOver  = (state == OVER);

endmodule

// File: tb/tb_pong_ctrl.sv
// Self-checking bench for pong_ctrl: directed scenarios followed by random play,
// every cycle compared against a behavioural game model.
module tb_pong_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int WIN_SCORE = 2;

    logic       clk, reset, start;
    logic       btnUpL, btnDownL, btnUpR, btnDownR, hitL, hitR;
    logic       moveUpL, moveDownL, moveUpR, moveDownR;
    logic       inRangeL, inRangeR, gameOver;
    logic [5:0] ballX;
    logic [4:0] ballY;
    logic [3:0] scoreL, scoreR;

    int nChecks = 0;
    int nFails  = 0;
    int pulseUpR = 0;
    int pulseL   = 0;

    // behavioural model: signed velocities, named phases, plain integers
    int         mX, mY, mVx, mVy, mSL, mSR, mCnt, mRally;
    string      mPhase, mLoser;
    logic [3:0] mS1, mS2;

    pong_ctrl #(.TICK_DIV(TICK_DIV), .WIN_SCORE(WIN_SCORE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .btnUpL(btnUpL), .btnDownL(btnDownL), .btnUpR(btnUpR), .btnDownR(btnDownR),
        .hitL(hitL), .hitR(hitR),
        .moveUpL(moveUpL), .moveDownL(moveDownL), .moveUpR(moveUpR), .moveDownR(moveDownR),
        .inRangeL(inRangeL), .inRangeR(inRangeR),
        .ballX(ballX), .ballY(ballY), .scoreL(scoreL), .scoreR(scoreR), .gameOver(gameOver)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mPeriod();
`ifdef PONG_SPEEDUP_EN
        return (mRally >= 8) ? TICK_DIV / 2 : TICK_DIV;
`else
        return TICK_DIV;
`endif
    endfunction

    function automatic bit mTick();
        return mCnt >= mPeriod() - 1;
    endfunction

    function automatic void modelReset();
        mX = 32; mY = 16; mVx = 1; mVy = 1;
        mSL = 0; mSR = 0; mCnt = 0; mRally = 0;
        mPhase = "idle"; mLoser = "";
        mS1 = '0; mS2 = '0;
    endfunction

    function automatic void modelAdvance();
        bit t;
        int nx, ny;
        t = mTick();
        mS2 = mS1;
        mS1 = {btnUpL, btnDownL, btnUpR, btnDownR};
        mCnt = t ? 0 : mCnt + 1;
        if (mPhase == "idle") begin
            if (start) mPhase = "move";
        end else if (mPhase == "move") begin
            if (t) begin
                ny = mY + mVy;
                if (ny < 0 || ny > 31) begin
                    mVy = -mVy;
                    ny  = mY + mVy;
                end
                mY = ny;
                nx = mX + mVx;
                if (nx == 0)       mPhase = "chkL";
                else if (nx == 63) mPhase = "chkR";
                else               mX = nx;
            end
        end else if (mPhase == "chkL") begin
            mPhase = "waitL";
        end else if (mPhase == "chkR") begin
            mPhase = "waitR";
        end else if (mPhase == "waitL") begin
            if (hitL) begin
                mVx = 1; mRally = (mRally < 15) ? mRally + 1 : 15; mPhase = "move";
            end else begin
                if (mSR < WIN_SCORE) mSR++;
                mLoser = "L"; mPhase = "point";
            end
        end else if (mPhase == "waitR") begin
            if (hitR) begin
                mVx = -1; mRally = (mRally < 15) ? mRally + 1 : 15; mPhase = "move";
            end else begin
                if (mSL < WIN_SCORE) mSL++;
                mLoser = "R"; mPhase = "point";
            end
        end else if (mPhase == "point") begin
            mX = 32; mY = 16; mRally = 0;
            mVx = (mLoser == "L") ? -1 : 1;
            mPhase = (mSL == WIN_SCORE || mSR == WIN_SCORE) ? "over" : "idle";
        end else if (mPhase == "over") begin
            if (start) begin
                mSL = 0; mSR = 0; mPhase = "idle";
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, compare every output against the model, then clock it
    task automatic applyStimulus(input logic st, input logic hL, input logic hR, input logic [3:0] btns);
        bit pe;
        start = st; hitL = hL; hitR = hR;
        {btnUpL, btnDownL, btnUpR, btnDownR} = btns;
        #1;
        pe = mTick() && mPhase != "point" && mPhase != "over";
        checkOutput("ballX", 32'(ballX), 32'(mX));
        checkOutput("ballY", 32'(ballY), 32'(mY));
        checkOutput("scoreL", 32'(scoreL), 32'(mSL));
        checkOutput("scoreR", 32'(scoreR), 32'(mSR));
        checkOutput("gameOver", 32'(gameOver), 32'(mPhase == "over"));
        checkOutput("inRangeL", 32'(inRangeL), 32'(mPhase == "chkL"));
        checkOutput("inRangeR", 32'(inRangeR), 32'(mPhase == "chkR"));
        checkOutput("moveUpL", 32'(moveUpL), 32'(pe && mS2[3] && !mS2[2]));
        checkOutput("moveDownL", 32'(moveDownL), 32'(pe && mS2[2] && !mS2[3]));
        checkOutput("moveUpR", 32'(moveUpR), 32'(pe && mS2[1] && !mS2[0]));
        checkOutput("moveDownR", 32'(moveDownR), 32'(pe && mS2[0] && !mS2[1]));
        if (moveUpR) pulseUpR++;
        if (moveUpL || moveDownL) pulseL++;
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [3:0] btns;
        reset = 1'b0; start = 1'b0; hitL = 1'b0; hitR = 1'b0;
        {btnUpL, btnDownL, btnUpR, btnDownR} = 4'b0;
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstBallX", 32'(ballX), 32);
        checkOutput("rstBallY", 32'(ballY), 16);
        checkOutput("rstScores", 32'({scoreL, scoreR}), 0);
        checkOutput("rstGameOver", 32'(gameOver), 0);
        @(negedge clk);
        reset = 1'b1;

        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0);
        checkOutput("idleHoldX", 32'(ballX), 32);
        checkOutput("idleHoldY", 32'(ballY), 16);

        $display("[TB] serve right, paddles always hit");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0);
        n = 0;
        while (mY != 31 && n < 200) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("reachWallY31", 32'(ballY), 31);
        n = 0;
        while (mY == 31 && n < 20) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("wallBounceY30", 32'(ballY), 30);
        n = 0;
        while (mPhase != "chkR" && n < 400) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("reachChkRBound", 32'(n < 400), 1);
        checkOutput("chkRBallX", 32'(ballX), 62);
        checkOutput("chkRInRange", 32'(inRangeR), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0);
        checkOutput("waitRInRangeOff", 32'(inRangeR), 0);
        n = 0;
        while (mX == 62 && n < 20) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("returnX61", 32'(ballX), 61);

        $display("[TB] left paddle misses");
        n = 0;
        while (mPhase != "idle" && n < 600) begin applyStimulus(1'b0, 1'b0, 1'b1, 4'b0); n++; end
        checkOutput("missScoreR", 32'(scoreR), 1);
        checkOutput("missScoreL", 32'(scoreL), 0);
        checkOutput("missCenterX", 32'(ballX), 32);
        checkOutput("missCenterY", 32'(ballY), 16);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0);
        n = 0;
        while (mX == 32 && n < 20) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("serveTowardLoser", 32'(ballX), 31);

        $display("[TB] button throttling");
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 4'b1110);
        pulseUpR = 0; pulseL = 0;
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b1, 4'b1110);
        checkOutput("upRPulseCount", 32'(pulseUpR), 10);
        checkOutput("bothLNoPulse", 32'(pulseL), 0);

        $display("[TB] second miss ends the game");
        n = 0;
        while (mPhase != "over" && n < 600) begin applyStimulus(1'b0, 1'b0, 1'b1, 4'b0); n++; end
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0);
        checkOutput("overFlag", 32'(gameOver), 1);
        checkOutput("overScoreR", 32'(scoreR), 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0);
        checkOutput("restartScores", 32'({scoreL, scoreR}), 0);
        checkOutput("restartGameOver", 32'(gameOver), 0);

        $display("[TB] reset during right check");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0);
        n = 0;
        while (mPhase != "chkR" && n < 800) begin applyStimulus(1'b0, 1'b1, 1'b1, 4'b0); n++; end
        checkOutput("reachChkR2", 32'(inRangeR), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncRstInRange", 32'(inRangeR), 0);
        checkOutput("asyncRstBallX", 32'(ballX), 32);
        checkOutput("asyncRstBallY", 32'(ballY), 16);
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("[TB] random play");
        btns = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) btns = 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0), btns);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
